// File: rtl/wb_rf_wport_arbiter.sv
// wb_rf_wport_arbiter
// Shares the single regfile write port between the in-order WB stage and a
// side requester (divider, uncached-load return). Side results are queued in
// a small FIFO and drained in WB idle cycles. If the queue keeps losing
// arbitration for STARVE_MAX cycles, WB is held for one cycle so the queue
// head can write.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   wb_valid/wb_dst/wb_data        WB stage write request
//   wb_hold                        WB lost the port; retry next cycle
//   side_valid/side_dst/side_data  side unit result
//   side_ready                     FIFO can accept (no bypass when full)
//   rf_we/rf_waddr/rf_wdata        registered regfile write port
//   fifo_count                     current FIFO occupancy
//   pend_mask                      registers targeted by queued side results
module wb_rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_dst,
    input  logic [31:0]                wb_data,
    output logic                       wb_hold,
    input  logic                       side_valid,
    input  logic [4:0]                 side_dst,
    input  logic [31:0]                side_data,
    output logic                       side_ready,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [31:0]                pend_mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } wr_req_t;

    wr_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] ent_vld_q;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [SW-1:0]    starve_q;

    logic    fifo_ne, starved, grant_fifo, grant_wb, push, pop;
    wr_req_t win;

    // Arbitration: a starved queue beats WB, otherwise WB beats the queue.
    always_comb begin
        fifo_ne    = (count_q != '0);
        starved    = fifo_ne && (starve_q == SW'(STARVE_MAX));
        grant_fifo = fifo_ne && (starved || !wb_valid);
        grant_wb   = wb_valid && !starved;
        wb_hold    = wb_valid && starved;
        side_ready = (count_q != CW'(DEPTH));
        push       = side_valid && side_ready;
        pop        = grant_fifo;
        win        = grant_fifo ? mem_q[rd_ptr_q]
                                : wr_req_t'{dst: wb_dst, data: wb_data};
    end

    // Pending mask follows the registered entry-valid bits, so a popped entry
    // drops out in the same cycle its rf_we is visible.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld_q[i]) pend_mask[mem_q[i].dst] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign fifo_count = count_q;

    // Payload storage needs no reset; validity is tracked in ent_vld_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_req_t'{dst: side_dst, data: side_data};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            // Push and pop never hit the same slot: push needs not-full,
            // pop needs not-empty, and the pointers only coincide at those.
            if (pop) begin
                ent_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q            <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                ent_vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (!fifo_ne || grant_fifo)
                starve_q <= '0;
            else if (starve_q != SW'(STARVE_MAX))
                starve_q <= starve_q + SW'(1);

            // r0 writes are consumed but never reach the regfile.
            if (grant_fifo || grant_wb) begin
                rf_we    <= (win.dst != 5'd0);
                rf_waddr <= win.dst;
                rf_wdata <= win.data;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_rf_wport_arbiter.sv
module tb_wb_rf_wport_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dst = '0;
    logic [31:0] wb_data = '0;
    logic        wb_hold;
    logic        side_valid = 1'b0;
    logic [4:0]  side_dst = '0;
    logic [31:0] side_data = '0;
    logic        side_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;
    logic [31:0] pend_mask;

    int n_chk  = 0;
    int n_fail = 0;
    logic [36:0] sb [$];   // expected writes {addr, data}, in order

    wb_rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .wb_hold(wb_hold),
        .side_valid(side_valid), .side_dst(side_dst), .side_data(side_data),
        .side_ready(side_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        sb.push_back({a, d});
    endtask

    // Drive one cycle's inputs just after the edge, then settle for checks.
    task automatic drive(input logic wv, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic sv, input logic [4:0] sd, input logic [31:0] sdat);
        @(posedge clk);
        #1;
        wb_valid = wv; wb_dst = wd; wb_data = wdat;
        side_valid = sv; side_dst = sd; side_data = sdat;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Write-port monitor: every rf_we pulse must match the scoreboard head.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexp_wr_sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(rf_waddr), 32'(e[36:32]));
                chk("wr_data", rf_wdata, e[31:0]);
            end
        end
    end

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #2;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_ready", 32'(side_ready), 1);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_hold", 32'(wb_hold), 0);

        // WB write with empty FIFO
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        exp_wr(5'd5, 32'h1234);
        chk("wb_hold0", 32'(wb_hold), 0);
        idle();

        // Side push, drained in an idle cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA5A5_A5A5);
        chk("side_ready_empty", 32'(side_ready), 1);
        idle();
        exp_wr(5'd9, 32'hA5A5_A5A5);
        chk("pend_after_push", pend_mask, 32'h200);
        chk("count_after_push", 32'(fifo_count), 1);
        idle();
        chk("count_after_drain", 32'(fifo_count), 0);
        chk("pend_after_drain", pend_mask, 0);

        // Starvation: queued dst=3 against continuous WB
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
        for (int c = 0; c < 6; c++) begin
            logic [4:0] d;
            d = (c < 4) ? 5'(10 + c) : 5'd14;
            drive(1'b1, d, 32'hB000_0000 + 32'(d), 1'b0, 5'd0, 32'd0);
            chk("starve_hold", 32'(wb_hold), (c == 4) ? 1 : 0);
            if (c == 4) exp_wr(5'd3, 32'h33);
            else        exp_wr(d, 32'hB000_0000 + 32'(d));
            if (c == 0) chk("starve_pend", pend_mask, 32'h8);
        end
        idle();
        chk("starve_count_end", 32'(fifo_count), 0);

        // Full FIFO with WB held busy; starvation clears and side_ready
        // stays low during the pop cycle.
        drive(1'b1, 5'd20, 32'hC20, 1'b1, 5'd21, 32'hD21);  exp_wr(5'd20, 32'hC20);
        drive(1'b1, 5'd22, 32'hC22, 1'b1, 5'd23, 32'hD23);  exp_wr(5'd22, 32'hC22);
        chk("fill_ready1", 32'(side_ready), 1);
        drive(1'b1, 5'd24, 32'hC24, 1'b1, 5'd25, 32'hD25);  exp_wr(5'd24, 32'hC24);
        chk("full_ready0", 32'(side_ready), 0);
        chk("full_count", 32'(fifo_count), 2);
        chk("full_pend", pend_mask, (32'h1 << 21) | (32'h1 << 23));
        drive(1'b1, 5'd26, 32'hC26, 1'b1, 5'd25, 32'hD25);  exp_wr(5'd26, 32'hC26);
        drive(1'b1, 5'd28, 32'hC28, 1'b1, 5'd25, 32'hD25);  exp_wr(5'd28, 32'hC28);
        drive(1'b1, 5'd30, 32'hC30, 1'b1, 5'd25, 32'hD25);  exp_wr(5'd21, 32'hD21);
        chk("full_pop_hold", 32'(wb_hold), 1);
        chk("full_pop_ready0", 32'(side_ready), 0);
        drive(1'b1, 5'd30, 32'hC30, 1'b1, 5'd25, 32'hD25);  exp_wr(5'd30, 32'hC30);
        chk("retry_hold0", 32'(wb_hold), 0);
        chk("retry_ready1", 32'(side_ready), 1);
        chk("retry_count", 32'(fifo_count), 1);
        idle(); exp_wr(5'd23, 32'hD23);
        chk("drain_count2", 32'(fifo_count), 2);
        idle(); exp_wr(5'd25, 32'hD25);
        idle();
        chk("drain_count0", 32'(fifo_count), 0);
        chk("drain_pend0", pend_mask, 0);

        // dst=0 side entry: consumed without a write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        idle();
        chk("r0_count1", 32'(fifo_count), 1);
        chk("r0_pend", pend_mask, 0);
        idle();
        chk("r0_count0", 32'(fifo_count), 0);
        chk("r0_we", 32'(rf_we), 0);

        // Reset with two entries queued discards them
        drive(1'b1, 5'd40, 32'hC40, 1'b1, 5'd41, 32'hD41);  exp_wr(5'd40, 32'hC40);
        drive(1'b1, 5'd42, 32'hC42, 1'b1, 5'd43, 32'hD43);  exp_wr(5'd42, 32'hC42);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        wb_valid = 1'b0; side_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        #2;
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_pend", pend_mask, 0);
        chk("mid_rst_we", 32'(rf_we), 0);
        chk("mid_rst_ready", 32'(side_ready), 1);
        repeat (4) idle();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_rf_wport_arbiter.md
Name: wb_rf_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order WB stage result and a side requester: multi-cycle units such as the divider and uncached-load return.
- Side results are buffered in a small FIFO and normally drained in WB idle cycles.
- A starvation counter forces a drain by holding WB, so side results always complete.
- Sits between the WB stage / side units and the regfile write port; also exports a pending-destination mask for the hazard scoreboard.

Parameters:
- DEPTH, 2, side FIFO entries (power of two, 2..8).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before WB is held.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wb_valid  in  1  WB stage has a register write this cycle (already gated by WB_DisWr)
- wb_dst  in  5  WB destination register
- wb_data  in  32  WB result
- wb_hold  out  1  WB lost the port; pipeline must freeze WB and retry next cycle
- side_valid  in  1  side unit presents a result
- side_dst  in  5  side destination
- side_data  in  32  side result
- side_ready  out  1  FIFO can accept; transfer occurs when side_valid && side_ready
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  32  regfile write data (registered)
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- pend_mask  out  32  bit i set iff some FIFO entry targets register i

Behaviour:
- Reset (resetn=0 at posedge):
  - FIFO emptied; read/write pointers = 0; starve counter = 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0; fifo_count=0; pend_mask=0.
  - side_ready=1 and wb_hold=0 from the first cycle after reset.
  - Reset mid-drain discards all queued side results.
- Grant decision (combinational, each cycle), first match wins:
  1. FIFO non-empty && starve==STARVE_MAX: grant FIFO head; wb_hold = wb_valid.
  2. wb_valid: grant WB; wb_hold=0.
  3. FIFO non-empty: grant FIFO head.
  4. Otherwise no grant.
- Write port:
  - Granted source's dst/data are registered into rf_waddr/rf_wdata with rf_we=1 on the next edge. Latency is 1 cycle.
  - If the granted dst==0: rf_we=0, but the request is still consumed (FIFO pops / WB not held).
  - No grant: rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when the FIFO is non-empty and not granted.
  - Clears to 0 when the FIFO head is granted or the FIFO is empty.
- FIFO:
  - side_ready = (fifo_count != DEPTH). There is no bypass of a full FIFO, even if a pop occurs in the same cycle.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - A pushed entry is eligible for grant the cycle after the push. There is no same-cycle enqueue-to-write bypass.
  - Pointers wrap modulo DEPTH.
- pend_mask:
  - Recomputed combinationally from the valid entries; bit 0 is always 0.
  - Reflects FIFO state after the last edge: a popped entry clears in the same cycle rf_we rises for it.
- WB flush does not affect this block; queued side results are architecturally committed.
- Ordering: the scoreboard must stall issue of any instruction whose dst is set in pend_mask. This block does not reorder writes to the same register.

Test Plan:
- Reset, then idle: rf_we=0, side_ready=1, fifo_count=0, pend_mask=0, wb_hold=0.
- wb_valid=1, dst=5, data=0x1234 with FIFO empty -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; wb_hold=0.
- Side push dst=9, data=0xA5A5A5A5, then wb_valid=0 -> pend_mask=0x200 after the push edge. The cycle after, rf_we=1, waddr=9; fifo_count returns to 0; pend_mask=0.
- FIFO holds dst=3 and wb_valid=1 continuously:
  - WB wins for 4 cycles.
  - On the 5th cycle wb_hold=1 and the FIFO entry writes (waddr=3).
  - The following cycle WB writes and the starve counter is 0.
- Push 2 side entries with wb_valid held 1 -> side_ready=0 with fifo_count=2. A third side_valid is not accepted until a pop; the same-cycle push+pop at full is refused.
- Side push with dst=0 -> entry popped with rf_we=0. Assert resetn=0 while 2 entries are queued -> next cycle fifo_count=0 and neither entry is ever written.
